// File: rtl/controle_ula_if.sv
// Signal bundle between controle_ula and its surroundings: host byte stream in,
// ULA operand/result lines, result byte stream out, and status.
interface controle_ula_if;
    logic         start;
    logic [3:0]   opcode_in;

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;

    logic [3:0]   ula_opcode;
    logic [7:0]   ula_escalar;
    logic [199:0] ula_matrizA;
    logic [199:0] ula_matrizB;
    logic [199:0] ula_resultado;
    logic         ula_done;

    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;

    logic         busy;
    logic         erro;

    // Environment side: host, ULA and result consumer.
    modport master (
        output start, opcode_in, in_data, in_valid, ula_resultado, ula_done, out_ready,
        input  in_ready, ula_opcode, ula_escalar, ula_matrizA, ula_matrizB,
               out_data, out_valid, busy, erro
    );

    // Controller side.
    modport slave (
        input  start, opcode_in, in_data, in_valid, ula_resultado, ula_done, out_ready,
        output in_ready, ula_opcode, ula_escalar, ula_matrizA, ula_matrizB,
               out_data, out_valid, busy, erro
    );
endinterface

// File: rtl/controle_ula.sv
// ULA sequencer: assembles 5x5 byte matrices (and a scalar) from the host stream,
// hands them to the ULA, waits for its result and serializes it back out.
module controle_ula #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    controle_ula_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StLoadEsc,
        StWait,
        StSend
    } state_e;

    localparam int unsigned WaitW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam logic [4:0] LastIdx    = 5'd24;
    localparam logic [3:0] OpFirst    = 4'd3;
    localparam logic [3:0] OpLast     = 4'd12;
    localparam logic [3:0] OpLoadBLo  = 4'd3;
    localparam logic [3:0] OpLoadBHi  = 4'd5;
    localparam logic [3:0] OpEscalar  = 4'd8;
    localparam logic [3:0] OpDetFirst = 4'd9;

    state_e           state_q, state_d;
    state_e           after_a;
    logic [3:0]       op_q, op_d;
    logic [4:0]       idx_q, idx_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [199:0]     mat_a_q, mat_a_d;
    logic [199:0]     mat_b_q, mat_b_d;
    logic [199:0]     res_q, res_d;
    logic [7:0]       esc_q, esc_d;
    logic             erro_q, erro_d;

    logic [7:0]       bit_base;
    logic             op_ok;
    logic             op_loads_b;
    logic             op_is_det;
    logic             send_last;

    assign bit_base   = {idx_q, 3'b000};
    assign op_ok      = (bus.opcode_in >= OpFirst) && (bus.opcode_in <= OpLast);
    assign op_loads_b = (op_q >= OpLoadBLo) && (op_q <= OpLoadBHi);
    assign op_is_det  = (op_q >= OpDetFirst);
    assign send_last  = op_is_det || (idx_q == LastIdx);

    always_comb begin
        if (op_loads_b) begin
            after_a = StLoadB;
        end else if (op_q == OpEscalar) begin
            after_a = StLoadEsc;
        end else begin
            after_a = StWait;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        esc_d   = esc_q;
        res_d   = res_q;
        erro_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (op_ok) begin
                        // Clear operands so unused B/scalar reach the ULA as zero.
                        op_d    = bus.opcode_in;
                        mat_a_d = '0;
                        mat_b_d = '0;
                        esc_d   = '0;
                        res_d   = '0;
                        state_d = StLoadA;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            StLoadA: begin
                if (bus.in_valid) begin
                    mat_a_d[bit_base +: 8] = bus.in_data;
                    if (idx_q == LastIdx) begin
                        state_d = after_a;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StLoadB: begin
                if (bus.in_valid) begin
                    mat_b_d[bit_base +: 8] = bus.in_data;
                    if (idx_q == LastIdx) begin
                        state_d = StWait;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StLoadEsc: begin
                if (bus.in_valid) begin
                    esc_d   = bus.in_data;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.ula_done) begin
                    res_d   = bus.ula_resultado;
                    state_d = StSend;
                end else if (wait_q == WaitLast) begin
                    erro_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StSend: begin
                if (bus.out_ready) begin
                    if (send_last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            idx_d  = '0;
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            esc_q   <= '0;
            res_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            esc_q   <= esc_d;
            res_q   <= res_d;
            erro_q  <= erro_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign bus.in_ready    = (state_q == StLoadA) || (state_q == StLoadB) ||
                             (state_q == StLoadEsc);
    assign bus.busy        = (state_q != StIdle);
    assign bus.out_valid   = (state_q == StSend);
    assign bus.out_data    = (state_q == StSend) ? res_q[bit_base +: 8] : 8'd0;
    assign bus.ula_opcode  = (state_q == StWait) ? op_q : 4'd0;
    assign bus.ula_escalar = esc_q;
    assign bus.ula_matrizA = mat_a_q;
    assign bus.ula_matrizB = mat_b_q;
    assign bus.erro        = erro_q;

    // A stalled output byte must not change under the consumer.
    assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: doc/controle_ula.md
CONTROLE_ULA -- requirements
Module: controle_ula

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles spent waiting for ula_done before aborting.
REQ-002 SHALL have port clk  in  1  the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port opcode_in  in  4  operation code, using the same encoding as the ULA.
REQ-006 SHALL have ports in_data  in  8, in_valid  in  1 and in_ready  out  1, forming the host byte-stream input.
REQ-007 SHALL have ports ula_opcode  out  4, ula_escalar  out  8, ula_matrizA  out  200 and ula_matrizB  out  200, driving the ULA inputs.
REQ-008 SHALL have ports ula_resultado  in  200 and ula_done  in  1, carrying the ULA outputs.
REQ-009 SHALL have ports out_data  out  8, out_valid  out  1 and out_ready  in  1, forming the result byte-stream output.
REQ-010 SHALL have ports busy  out  1 (high whenever not in IDLE) and erro  out  1 (one-cycle error pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_ESC, WAIT and SEND.
REQ-012 IDLE, on start=1: SHALL latch opcode_in and go to LOAD_A if the opcode is 0011..1100.
 - Any other opcode: pulse erro for one cycle and stay in IDLE.
REQ-013 A byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
 - in_ready=1 exactly in LOAD_A, LOAD_B and LOAD_ESC.
REQ-014 LOAD_A and LOAD_B SHALL each accept 25 bytes.
 - Byte k (0..24, row-major) is stored at bits [8k+7:8k] of the matrix.
 - A 5-bit counter tracks k and clears on every state change.
REQ-015 After the 25th A byte, the next state SHALL be:
 - LOAD_B for opcodes 0011, 0100 and 0101;
 - LOAD_ESC for opcode 1000;
 - WAIT for all other valid opcodes.
REQ-016 LOAD_B exit SHALL go to WAIT; LOAD_ESC SHALL accept one byte into ula_escalar and then go to WAIT.
REQ-017 For opcodes that do not load B or the scalar, ula_matrizB and ula_escalar SHALL hold zero.
REQ-018 ula_opcode SHALL equal the latched opcode only while in WAIT, and 0000 in every other state.
REQ-019 WAIT SHALL capture ula_resultado into a 200-bit result register on the first cycle with ula_done=1, then go to SEND.
 - The earliest capture is the second WAIT cycle, because the ULA output is registered.
REQ-020 WAIT SHALL count cycles; if TIMEOUT cycles elapse without ula_done, it SHALL pulse erro and return to IDLE without sending.
REQ-021 SEND SHALL present the result bytes with out_valid=1.
 - Matrix opcodes (0011..1000): 25 bytes, index 0..24, out_data = result[8k+7:8k].
 - Determinant opcodes (1001..1100): a single byte, result[7:0].
REQ-022 In SEND, out_data SHALL stay stable while out_valid=1 and out_ready=0; the index SHALL advance only when out_ready=1.
REQ-023 After the last byte is accepted, the block SHALL return to IDLE with out_valid=0 in the following cycle.
REQ-024 While busy=1, start SHALL be ignored.
 - in_valid SHALL be ignored outside the LOAD states.
REQ-025 All arithmetic SHALL be done by the ULA; this block SHALL only assemble matrices and serialize the result, with no width conversion.

Reset
REQ-026 rst=1 SHALL, asynchronously and at any time including mid-operation, force:
 - state=IDLE;
 - counters=0;
 - matrices, scalar and result=0;
 - ula_opcode=0000;
 - in_ready=0, out_valid=0, busy=0, erro=0;
 - out_data=0.
REQ-027 After rst is released, the first start SHALL be honoured on the first rising edge at which rst=0.

Verification
REQ-028 Soma: start with opcode 0011; A bytes all 1, B bytes all 2; ula model with 1-cycle latency -> ula_opcode=0011 during WAIT; 25 out bytes, each 3; then IDLE.
REQ-029 Scalar: opcode 1000; A bytes 0..24; scalar byte 3 -> ula_escalar=3 and ula_matrizB=0 during WAIT; 25 bytes are output.
REQ-030 Determinant 2x2: opcode 1001; 25 A bytes only -> WAIT is entered with no LOAD_B; exactly 1 out byte, equal to ula_resultado[7:0].
REQ-031 Backpressure: in_valid toggles every cycle and out_ready is low for 5 cycles at byte 10 -> no byte is lost or duplicated; out_data holds during the stall.
REQ-032 Timeout and invalid opcode:
 - ula_done held at 0 -> erro pulses for one cycle after 64 WAIT cycles, then IDLE.
 - start with opcode 0000 -> erro pulses for one cycle, busy stays 0.
REQ-033 Reset mid-operation: rst asserted during LOAD_B at byte 12 -> in_ready=0 and busy=0 immediately; a subsequent operation loads A starting from index 0.
